// File: rtl/icache_responder_if.sv
// icache_responder_if: fetch-side, memory-side and statistics signals of the instruction cache
interface icache_responder_if #(parameter int CNTW = 16);
  logic            imemREN;
  logic [31:0]     imemaddr;
  logic            flush;
  logic            ihit;
  logic [31:0]     imemload;
  logic            iREN;
  logic [31:0]     iaddr;
  logic            iwait;
  logic [31:0]     iload;
  logic [CNTW-1:0] hit_count;
  logic [CNTW-1:0] miss_count;
  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
endinterface

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped one-word-per-line instruction cache with a blocking single-read miss fill
module icache_responder #(
  parameter int NSETS = 16,
  parameter int CNTW  = 16
) (
  input logic CLK,
  input logic RST,
  icache_responder_if.slave bus
);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;
  typedef enum logic {IDLE, FETCH} state_t;
  state_t           state;
  logic [NSETS-1:0] valid;
  logic [TAGW-1:0]  tags [NSETS];
  logic [31:0]      data [NSETS];
  logic [31:0]      addr;
  logic [CNTW-1:0]  hits;
  logic [CNTW-1:0]  misses;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  cidx;
  logic [TAGW-1:0]  tag;
  logic [TAGW-1:0]  ctag;
  logic             hit;
  logic             miss;
  logic             fill;
  assign idx  = bus.imemaddr[IDXW+1:2];
  assign tag  = bus.imemaddr[31:IDXW+2];
  assign cidx = addr[IDXW+1:2];
  assign ctag = addr[31:IDXW+2];
  // flush suppresses both the hit and a new miss in the same cycle
  always_comb begin
    hit  = state == IDLE && bus.imemREN && !bus.flush && valid[idx] && tags[idx] == tag;
    miss = state == IDLE && bus.imemREN && !bus.flush && !hit;
    fill = state == FETCH && !bus.flush && !bus.iwait;
  end
  assign bus.ihit       = hit;
  assign bus.imemload   = hit ? data[idx] : 32'h0;
  assign bus.iREN       = state == FETCH;
  assign bus.iaddr      = addr;
  assign bus.hit_count  = hits;
  assign bus.miss_count = misses;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      valid  <= '0;
      addr   <= '0;
      hits   <= '0;
      misses <= '0;
    end else begin
      state  <= miss ? FETCH : (state == FETCH && (bus.flush || !bus.iwait)) ? IDLE : state;
      valid  <= bus.flush ? '0 : fill ? valid | (NSETS'(1) << cidx) : valid;
      addr   <= miss ? bus.imemaddr & ~32'h3 : addr;
      hits   <= hits + CNTW'(hit && !(&hits));
      misses <= misses + CNTW'(miss && !(&misses));
    end
  end
  // tag/data arrays carry no reset; valid alone qualifies them
  always_ff @(posedge CLK) begin
    if (fill && !RST) begin
      tags[cidx] <= ctag;
      data[cidx] <= bus.iload;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed cycle-by-cycle checks of hit, miss fill, redirect, flush, reset and saturation
module tb_icache_responder;
  logic CLK = 0;
  logic RST;
  int   errors = 0;
  int   checks = 0;
  icache_responder_if #(.CNTW(4)) bus ();
  icache_responder #(.NSETS(16), .CNTW(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic drive(input logic ren, input logic [31:0] a, input logic fl, input logic w, input logic [31:0] ld);
    bus.imemREN = ren; bus.imemaddr = a; bus.flush = fl; bus.iwait = w; bus.iload = ld;
    #1;
  endtask
  // miss on a, hold iwait for waits cycles, then fill with d
  task automatic fill(input logic [31:0] a, input logic [31:0] d, input int waits);
    drive(1, a, 0, 1, 0);
    chk("fill_miss_ihit", 32'(bus.ihit), 0);
    tick();
    for (int i = 0; i < waits; i++) begin
      drive(1, a, 0, 1, 0);
      chk("fill_wait_iren", 32'(bus.iREN), 1);
      tick();
    end
    drive(1, a, 0, 0, d);
    chk("fill_iren", 32'(bus.iREN), 1);
    chk("fill_iaddr", bus.iaddr, a & ~32'h3);
    tick();
  endtask
  initial begin
    RST = 1;
    drive(0, 0, 0, 1, 0);
    tick(); tick();
    RST = 0;
    drive(0, 0, 0, 1, 0);
    chk("rst_ihit", 32'(bus.ihit), 0);
    chk("rst_iren", 32'(bus.iREN), 0);
    chk("rst_iaddr", bus.iaddr, 0);
    chk("rst_load", bus.imemload, 0);
    chk("rst_hits", 32'(bus.hit_count), 0);
    chk("rst_misses", 32'(bus.miss_count), 0);
    // cold miss at 0x4 with two wait cycles
    drive(1, 32'h4, 0, 1, 0);
    chk("cold_ihit", 32'(bus.ihit), 0);
    chk("cold_iren_idle", 32'(bus.iREN), 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h4, 0, 1, 0);
      chk("cold_iren_wait", 32'(bus.iREN), 1);
      chk("cold_iaddr", bus.iaddr, 32'h4);
      chk("cold_ihit_fetch", 32'(bus.ihit), 0);
      tick();
    end
    drive(1, 32'h4, 0, 0, 32'h2008_0001);
    chk("cold_iren_last", 32'(bus.iREN), 1);
    tick();
    drive(1, 32'h4, 0, 1, 0);
    chk("cold_hit", 32'(bus.ihit), 1);
    chk("cold_load", bus.imemload, 32'h2008_0001);
    chk("cold_iren_done", 32'(bus.iREN), 0);
    chk("cold_misses", 32'(bus.miss_count), 1);
    tick();
    drive(0, 32'h4, 0, 1, 0);
    chk("cold_hits", 32'(bus.hit_count), 1);
    chk("noren_load", bus.imemload, 0);
    // conflict: 0x00 and 0x40 share index 0
    fill(32'h0, 32'hA0, 0);
    drive(1, 32'h0, 0, 1, 0);
    chk("conf_hit0", 32'(bus.ihit), 1);
    chk("conf_load0", bus.imemload, 32'hA0);
    tick();
    fill(32'h40, 32'hB0, 0);
    fill(32'h0, 32'hA1, 0);
    drive(0, 32'h0, 0, 1, 0);
    chk("conf_misses", 32'(bus.miss_count), 4);
    chk("conf_hits", 32'(bus.hit_count), 2);
    drive(1, 32'h0, 0, 1, 0);
    chk("conf_reload", bus.imemload, 32'hA1);
    tick();
    // redirect from 0x10 to 0x20 during the fill
    drive(1, 32'h10, 0, 1, 0);
    tick();
    drive(1, 32'h20, 0, 1, 0);
    chk("redir_ihit", 32'(bus.ihit), 0);
    chk("redir_iaddr", bus.iaddr, 32'h10);
    tick();
    drive(1, 32'h20, 0, 0, 32'hC0);
    chk("redir_iaddr2", bus.iaddr, 32'h10);
    tick();
    drive(1, 32'h20, 0, 1, 0);
    chk("redir_new_miss", 32'(bus.ihit), 0);
    tick();
    drive(1, 32'h20, 0, 0, 32'hD0);
    chk("redir_iaddr3", bus.iaddr, 32'h20);
    tick();
    drive(1, 32'h10, 0, 1, 0);
    chk("redir_hit10", 32'(bus.ihit), 1);
    chk("redir_load10", bus.imemload, 32'hC0);
    tick();
    drive(1, 32'h20, 0, 1, 0);
    chk("redir_load20", bus.imemload, 32'hD0);
    tick();
    drive(0, 0, 0, 1, 0);
    chk("redir_misses", 32'(bus.miss_count), 6);
    chk("redir_hits", 32'(bus.hit_count), 5);
    // flush in IDLE
    fill(32'h8, 32'hE0, 1);
    drive(1, 32'h8, 0, 1, 0);
    chk("fl_prehit", 32'(bus.ihit), 1);
    tick();
    drive(1, 32'h8, 1, 1, 0);
    chk("fl_ihit_forced", 32'(bus.ihit), 0);
    tick();
    drive(0, 32'h8, 0, 1, 0);
    chk("fl_no_miss", 32'(bus.iREN), 0);
    chk("fl_misses", 32'(bus.miss_count), 7);
    fill(32'h8, 32'hE1, 0);
    drive(1, 32'h8, 0, 1, 0);
    chk("fl_refill", bus.imemload, 32'hE1);
    tick();
    // flush in FETCH with iwait=0 drops the fill
    drive(1, 32'h4, 0, 1, 0);
    tick();
    drive(1, 32'h4, 1, 0, 32'hF0);
    chk("flf_iren", 32'(bus.iREN), 1);
    tick();
    drive(0, 32'h4, 0, 1, 0);
    chk("flf_idle", 32'(bus.iREN), 0);
    drive(1, 32'h4, 0, 1, 0);
    chk("flf_not_written", 32'(bus.ihit), 0);
    drive(1, 32'h8, 0, 1, 0);
    chk("flf_cleared", 32'(bus.ihit), 0);
    // reset mid-fill abandons it
    tick();
    RST = 1;
    drive(1, 32'h8, 0, 0, 32'h99);
    tick();
    RST = 0;
    drive(0, 32'h8, 0, 1, 0);
    chk("rstf_iren", 32'(bus.iREN), 0);
    chk("rstf_iaddr", bus.iaddr, 0);
    chk("rstf_misses", 32'(bus.miss_count), 0);
    drive(1, 32'h8, 0, 1, 0);
    chk("rstf_not_written", 32'(bus.ihit), 0);
    // hit counter saturation at 4'hF
    fill(32'h4, 32'h1234, 0);
    drive(1, 32'h4, 0, 1, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_15", 32'(bus.hit_count), 15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_20", 32'(bus.hit_count), 15);
    chk("sat_ihit", 32'(bus.ihit), 1);
    chk("sat_misses", 32'(bus.miss_count), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
